// File: rtl/stream_checker.sv
// stream_checker: syncs on PATTERN_A, then checks NUM_WORDS alternating A/B words with error counting.
// Optional STREAM_CHECKER_HALT_ON_ERR_EN ends the run at the first mismatch.
module stream_checker #(
    parameter logic [7:0] PATTERN_A = 8'hFF,
    parameter logic [7:0] PATTERN_B = 8'hAA,
    parameter int         NUM_WORDS = 16,
    parameter int         TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       timeout,
    output logic [7:0] match_count,
    output logic [7:0] err_count,
    output logic [7:0] first_err_data
);
    typedef enum logic [1:0] {IDLE, SYNC, CHECK, DONE} state_t;
    localparam logic [7:0]  LAST_IDX = 8'(NUM_WORDS - 1);
    localparam logic [15:0] CNT_MAX  = 16'(TIMEOUT - 1);
    state_t      r_state, w_next;
    logic [7:0]  r_idx, r_match, r_err, r_first;
    logic [15:0] r_cnt;
    logic        r_timeout;
    logic        w_enter, w_sync_hit, w_expire, w_cmp, w_mis, w_last, w_halt;
    logic [7:0]  w_exp;
    assign w_enter    = start && (r_state == IDLE || r_state == DONE);
    assign w_sync_hit = r_state == SYNC && data_valid && data_in == PATTERN_A;
    assign w_expire   = r_state == SYNC && !w_sync_hit && r_cnt == CNT_MAX;
    assign w_cmp      = r_state == CHECK && data_valid;
    assign w_exp      = r_idx[0] ? PATTERN_B : PATTERN_A;
    assign w_mis      = w_cmp && data_in != w_exp;
    assign w_last     = w_cmp && r_idx == LAST_IDX;
`ifdef STREAM_CHECKER_HALT_ON_ERR_EN
    assign w_halt = w_mis;
`else
    assign w_halt = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? SYNC : IDLE;
            SYNC:    w_next = w_sync_hit ? CHECK : w_expire ? DONE : SYNC;
            CHECK:   w_next = (w_last || w_halt) ? DONE : CHECK;
            DONE:    w_next = start ? SYNC : DONE;
            default: w_next = IDLE;
        endcase
    end
    // The sync word itself is word 0 and counts as the first match.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_idx     <= '0;
            r_match   <= '0;
            r_err     <= '0;
            r_first   <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (w_enter) begin
            r_idx     <= '0;
            r_match   <= '0;
            r_err     <= '0;
            r_first   <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == SYNC) begin
            if (w_sync_hit) begin
                r_idx   <= 8'd1;
                r_match <= 8'd1;
            end else begin
                r_cnt <= r_cnt + 16'd1;
                if (w_expire) r_timeout <= 1'b1;
            end
        end else if (w_cmp) begin
            r_idx <= r_idx + 8'd1;
            if (w_mis) begin
                if (r_err != 8'hFF) r_err <= r_err + 8'd1;
                if (r_err == 8'd0)  r_first <= data_in;
            end else
                r_match <= r_match + 8'd1;
        end
    assign busy           = r_state == SYNC || r_state == CHECK;
    assign done           = r_state == DONE;
    assign pass           = done && r_err == 8'd0 && !r_timeout;
    assign timeout        = r_timeout;
    assign match_count    = r_match;
    assign err_count      = r_err;
    assign first_err_data = r_first;
endmodule

// File: tb/tb_stream_checker.sv
// tb_stream_checker: directed vectors with hand-computed results for stream_checker.
module tb_stream_checker;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, data_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       busy, done, pass, timeout;
    logic [7:0] match_count, err_count, first_err_data;
    logic [7:0] vec [16];
    int         n_total = 0, n_bad = 0;

    always #5 clk = ~clk;

    stream_checker dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .data_valid(data_valid),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .match_count(match_count), .err_count(err_count), .first_err_data(first_err_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic s);
        data_in = d; data_valid = 1'b1; start = s;
        tick();
        data_valid = 1'b0; start = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_good();
        for (int i = 0; i < 16; i++) vec[i] = (i % 2 == 1) ? 8'hAA : 8'hFF;
    endtask

    // Gap cycles carry junk data and stray start pulses that must be ignored.
    task automatic send_range(input int lo, input int hi, input bit gaps);
        for (int i = lo; i < hi; i++) begin
            send(vec[i], gaps && i == 7);
            if (gaps) begin
                data_in = 8'h33; start = (i == 4 || i == 9);
                tick();
                start = 1'b0;
            end
        end
    endtask

    task automatic check_res(input string tag, input logic d, input logic p,
                             input logic [7:0] m, input logic [7:0] e, input logic [7:0] f);
        check({tag, "_done"}, done, d);
        check({tag, "_pass"}, pass, p);
        check({tag, "_match"}, match_count, m);
        check({tag, "_err"}, err_count, e);
        check({tag, "_first"}, first_err_data, f);
    endtask

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        check_res("rst", 0, 0, 8'd0, 8'd0, 8'd0);
        rst = 1'b0;
        tick();
        tick();
        check("idle_busy", busy, 0);

        load_good();
        pulse_start();
        check("t1_busy", busy, 1);
        send_range(0, 16, 0);
        check("t1_busy_end", busy, 0);
        check_res("t1", 1, 1, 8'd16, 8'd0, 8'd0);
        tick();
        tick();
        check("t1_hold_done", done, 1);
        check("t1_hold_match", match_count, 16);

        send(8'hFF, 1'b1);
        check("t2_busy", busy, 1);
        check("t2_nocount", match_count, 0);
        repeat (3) send(8'h00, 1'b0);
        check("t2_zero_ignored", match_count, 0);
        check("t2_zero_noerr", err_count, 0);
        send_range(0, 16, 0);
        check_res("t2", 1, 1, 8'd16, 8'd0, 8'd0);

        load_good();
        vec[5] = 8'h55;
        pulse_start();
`ifdef STREAM_CHECKER_HALT_ON_ERR_EN
        send_range(0, 6, 0);
        check_res("t3", 1, 0, 8'd5, 8'd1, 8'h55);
`else
        send_range(0, 6, 0);
        check("t3_running", busy, 1);
        send_range(6, 16, 0);
        check_res("t3", 1, 0, 8'd15, 8'd1, 8'h55);
`endif

        load_good();
        vec[3] = 8'h11;
        vec[8] = 8'h22;
        pulse_start();
`ifdef STREAM_CHECKER_HALT_ON_ERR_EN
        send_range(0, 4, 0);
        check_res("t3b", 1, 0, 8'd3, 8'd1, 8'h11);
`else
        send_range(0, 16, 0);
        check_res("t3b", 1, 0, 8'd14, 8'd2, 8'h11);
`endif

        pulse_start();
        repeat (999) tick();
        check("t4_before_busy", busy, 1);
        check("t4_before_to", timeout, 0);
        tick();
        check("t4_timeout", timeout, 1);
        check_res("t4", 1, 0, 8'd0, 8'd0, 8'd0);
        pulse_start();
        check("t4_restart_to", timeout, 0);
        check("t4_restart_busy", busy, 1);

        load_good();
        send_range(0, 8, 0);
        check("t5_mid_match", match_count, 8);
        #3 rst = 1'b1;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_to", timeout, 0);
        check_res("t5_rst", 0, 0, 8'd0, 8'd0, 8'd0);
        #2 rst = 1'b0;
        tick();
        tick();
        check("t5_idle_busy", busy, 0);
        check("t5_idle_done", done, 0);
        pulse_start();
        send_range(0, 16, 0);
        check_res("t5", 1, 1, 8'd16, 8'd0, 8'd0);

        pulse_start();
        send_range(0, 8, 1);
        check("t6_mid_match", match_count, 8);
        check("t6_mid_busy", busy, 1);
        send_range(8, 16, 1);
        check_res("t6", 1, 1, 8'd16, 8'd0, 8'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
